fpu_result_collector: RTL and testbench

Drain-side companion to the FP arithmetic top level. It captures each 64-bit result the arithmetic unit produces (C_out), tagged with the program counter of the issuing instruction, into a small FIFO for host or bench read-back. It classifies every accepted result per IEEE-754 double and keeps sticky exception flags. It reports completion once the instruction sequencer has stopped and all results have been read.

---
 rtl/fpu_result_collector.sv | 202 ++++++++++++++++++++
 tb/tb_fpu_result_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_collector.sv
// fpu_result_collector
// Captures tagged 64-bit FP results into a small FIFO for host read-back.
// Classifies each accepted result (NaN / Inf / zero) into sticky flags and a
// saturating zero counter, and raises done once the sequencer has stopped and
// every captured result has been popped.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   res_valid         result strobe, one cycle per result
//   res_data, res_tag result word (IEEE-754 double) and issuing PC
//   stop_in           sequencer stop level
//   rd_en             host pop request
//   rd_data, rd_tag   popped entry, valid when rd_valid=1 (held otherwise)
//   empty, full,count FIFO occupancy status (registered)
//   overflow          sticky: a result was dropped because the FIFO was full
//   nan_flag,inf_flag sticky classification flags
//   zero_cnt          accepted +/-0 results, saturating at 255
//   done              sequencer stopped and all results drained
module fpu_result_collector #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             res_valid,
   input  logic [63:0]      res_data,
   input  logic [TAG_W-1:0] res_tag,
   input  logic             stop_in,
   input  logic             rd_en,
   output logic [63:0]      rd_data,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             nan_flag,
   output logic             inf_flag,
   output logic [7:0]       zero_cnt,
   output logic             done
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = TAG_W + 64;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [EW-1:0]    mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic [63:0]      rd_data_q, rd_data_d;
   logic [TAG_W-1:0] rd_tag_q, rd_tag_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;
   logic             nan_q, nan_d;
   logic             inf_q, inf_d;
   logic [7:0]       zero_cnt_q, zero_cnt_d;
   logic             done_q, done_d;
   state_t           state_q, state_d;

   logic             wr_acc;
   logic             rd_acc;
   logic [10:0]      res_exp;
   logic [51:0]      res_man;
   logic             is_nan, is_inf, is_zero;
   logic [EW-1:0]    rd_entry;

   // A write is accepted when there is room, or when a pop frees a slot on the same edge
   assign wr_acc   = res_valid & (~full_q | rd_en);
   assign rd_acc   = rd_en & ~empty_q;
   assign rd_entry = mem_q[rd_ptr_q];

   // IEEE-754 double classification of the incoming word
   assign res_exp = res_data[62:52];
   assign res_man = res_data[51:0];
   assign is_nan  = (&res_exp) & (|res_man);
   assign is_inf  = (&res_exp) & ~(|res_man);
   assign is_zero = ~(|res_exp) & ~(|res_man);

   // Storage array; contents need no reset since occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= {res_tag, res_data};
      end
   end

   // Datapath next-state: pointers, occupancy, read port, flags
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_tag_d   = rd_tag_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;
      nan_d      = nan_q;
      inf_d      = inf_q;
      zero_cnt_d = zero_cnt_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (is_nan) nan_d = 1'b1;
         if (is_inf) inf_d = 1'b1;
         if (is_zero && (zero_cnt_q != 8'hFF)) zero_cnt_d = zero_cnt_q + 8'd1;
      end else if (res_valid) begin
         overflow_d = 1'b1;
      end

      // Pop reads the pre-edge head, so a same-edge write never falls through
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         rd_data_d  = rd_entry[63:0];
         rd_tag_d   = rd_entry[EW-1:64];
         rd_valid_d = 1'b1;
      end

      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      empty_d = (count_d == '0);
      full_d  = (count_d == FULL_CNT);
   end

   // Completion FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (wr_acc)       state_d = S_RUN;
            else if (stop_in) state_d = S_DONE;
         end
         S_RUN: begin
            if (stop_in) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (wr_acc || !stop_in)                  state_d = S_RUN;
            else if (empty_q && !rd_acc)             state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_tag_q   <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         nan_q      <= 1'b0;
         inf_q      <= 1'b0;
         zero_cnt_q <= '0;
         done_q     <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         rd_data_q  <= rd_data_d;
         rd_tag_q   <= rd_tag_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
         nan_q      <= nan_d;
         inf_q      <= inf_d;
         zero_cnt_q <= zero_cnt_d;
         done_q     <= done_d;
         state_q    <= state_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_tag   = rd_tag_q;
   assign rd_valid = rd_valid_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign nan_flag = nan_q;
   assign inf_flag = inf_q;
   assign zero_cnt = zero_cnt_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Testbench for fpu_result_collector: directed vector table, hand-written
// multi-cycle sequences (full/overflow, completion, reset) and a randomized
// run checked against a queue-based reference model.
module tb_fpu_result_collector;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned TAG_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             res_valid;
   logic [63:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             stop_in;
   logic             rd_en;
   logic [63:0]      rd_data;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_valid;
   logic             empty;
   logic             full;
   logic [AW:0]      count;
   logic             overflow;
   logic             nan_flag;
   logic             inf_flag;
   logic [7:0]       zero_cnt;
   logic             done;

   int n_tests = 0;
   int n_fail  = 0;

   fpu_result_collector #(.DEPTH(DEPTH), .AW(AW), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
      .res_tag(res_tag), .stop_in(stop_in), .rd_en(rd_en), .rd_data(rd_data),
      .rd_tag(rd_tag), .rd_valid(rd_valid), .empty(empty), .full(full),
      .count(count), .overflow(overflow), .nan_flag(nan_flag),
      .inf_flag(inf_flag), .zero_cnt(zero_cnt), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      res_valid = 1'b0;
      res_data  = '0;
      res_tag   = '0;
      rd_en     = 1'b0;
      stop_in   = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #10;
      rst = 1'b0;
   endtask

   task automatic drive(input logic wv, input logic [63:0] d, input logic [7:0] t, input logic re);
      res_valid = wv;
      res_data  = d;
      res_tag   = t;
      rd_en     = re;
   endtask

   typedef struct {
      logic        wv;
      logic [63:0] d;
      logic [7:0]  t;
      logic        re;
      logic [3:0]  c;
      logic        rv;
      logic [63:0] rd;
      logic [7:0]  rt;
      logic        nan;
      logic        inf;
      logic [7:0]  zc;
   } vec_t;

   function automatic vec_t mk(logic wv, logic [63:0] d, logic [7:0] t, logic re,
                               logic [3:0] c, logic rv, logic [63:0] rd, logic [7:0] rt,
                               logic nan, logic inf, logic [7:0] zc);
      vec_t v;
      v.wv = wv; v.d = d; v.t = t; v.re = re; v.c = c; v.rv = rv;
      v.rd = rd; v.rt = rt; v.nan = nan; v.inf = inf; v.zc = zc;
      return v;
   endfunction

   // Random result generator covering each classification bucket
   function automatic logic [63:0] gen_data();
      logic [63:0] d;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      d   = {$urandom, $urandom};
      case (sel)
         0: begin d[62:52] = 11'h7FF; if (d[51:0] == 52'd0) d[0] = 1'b1; end
         1: begin d[62:52] = 11'h7FF; d[51:0] = '0; end
         2, 3: begin d[62:0] = '0; end
         4: begin d[62:52] = '0; if (d[51:0] == 52'd0) d[5] = 1'b1; end
         default: ;
      endcase
      return d;
   endfunction

   vec_t tbl[12];
   logic [71:0] mq[$];
   logic [71:0] ent;
   logic [63:0] m_rd;
   logic [7:0]  m_rt;
   logic        m_rv, m_ovf, m_nan, m_inf;
   int          m_zc;

   initial begin
      rst = 1'b1;
      idle_inputs();
      #2;
      chk("rst_empty_during", 64'(empty), 64'd1);
      chk("rst_done_during", 64'(done), 64'd0);
      #8;
      rst = 1'b0;
      #1;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_flags", 64'({overflow, nan_flag, inf_flag}), 64'd0);
      chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      @(negedge clk);
      rd_en = 1'b1;
      cyc();
      chk("empty_pop_rv", 64'(rd_valid), 64'd0);
      chk("empty_pop_count", 64'(count), 64'd0);

      // ---------------- directed vector table ----------------
      tbl[0]  = mk(1, 64'h3FF0000000000000, 8'h01, 0, 1, 0, 64'h0, 8'h00, 0, 0, 0);
      tbl[1]  = mk(1, 64'h4000000000000000, 8'h02, 0, 2, 0, 64'h0, 8'h00, 0, 0, 0);
      tbl[2]  = mk(0, 64'h0, 8'h00, 1, 1, 1, 64'h3FF0000000000000, 8'h01, 0, 0, 0);
      tbl[3]  = mk(0, 64'h0, 8'h00, 1, 0, 1, 64'h4000000000000000, 8'h02, 0, 0, 0);
      tbl[4]  = mk(0, 64'h0, 8'h00, 1, 0, 0, 64'h4000000000000000, 8'h02, 0, 0, 0);
      tbl[5]  = mk(1, 64'h7FF8000000000000, 8'h10, 0, 1, 0, 64'h4000000000000000, 8'h02, 1, 0, 0);
      tbl[6]  = mk(1, 64'h7FF0000000000000, 8'h11, 0, 2, 0, 64'h4000000000000000, 8'h02, 1, 1, 0);
      tbl[7]  = mk(1, 64'h8000000000000000, 8'h12, 0, 3, 0, 64'h4000000000000000, 8'h02, 1, 1, 1);
      tbl[8]  = mk(1, 64'h0000000000000000, 8'h13, 0, 4, 0, 64'h4000000000000000, 8'h02, 1, 1, 2);
      tbl[9]  = mk(1, 64'h0000000000000001, 8'h14, 0, 5, 0, 64'h4000000000000000, 8'h02, 1, 1, 2);
      tbl[10] = mk(1, 64'h3FF0000000000000, 8'h15, 1, 5, 1, 64'h7FF8000000000000, 8'h10, 1, 1, 2);
      tbl[11] = mk(0, 64'h0, 8'h00, 0, 5, 0, 64'h7FF8000000000000, 8'h10, 1, 1, 2);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].wv, tbl[i].d, tbl[i].t, tbl[i].re);
         cyc();
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].c));
         chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].c == 4'd0));
         chk($sformatf("tbl%0d_rv", i), 64'(rd_valid), 64'(tbl[i].rv));
         chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].rd);
         chk($sformatf("tbl%0d_rd_tag", i), 64'(rd_tag), 64'(tbl[i].rt));
         chk($sformatf("tbl%0d_nan", i), 64'(nan_flag), 64'(tbl[i].nan));
         chk($sformatf("tbl%0d_inf", i), 64'(inf_flag), 64'(tbl[i].inf));
         chk($sformatf("tbl%0d_zc", i), 64'(zero_cnt), 64'(tbl[i].zc));
         chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'd0);
      end

      // ---------------- full / overflow / write+read at full ----------------
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 64'h3FF0000000000000 | 64'(i), 8'(i), 1'b0);
         cyc();
         chk($sformatf("fill%0d_count", i), 64'(count), 64'((i < 8) ? i + 1 : 8));
         chk($sformatf("fill%0d_full", i), 64'(full), 64'(i >= 7));
         chk($sformatf("fill%0d_ovf", i), 64'(overflow), 64'(i >= 8));
      end
      drive(1'b1, 64'hC000000000000000, 8'h99, 1'b1);
      cyc();
      chk("wr_rd_full_count", 64'(count), 64'd8);
      chk("wr_rd_full_rv", 64'(rd_valid), 64'd1);
      chk("wr_rd_full_data", rd_data, 64'h3FF0000000000000);
      chk("wr_rd_full_tag", 64'(rd_tag), 64'd0);
      chk("wr_rd_full_ovf", 64'(overflow), 64'd1);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 64'h0, 8'h0, 1'b1);
         cyc();
         chk($sformatf("drain%0d_rv", k), 64'(rd_valid), 64'd1);
         chk($sformatf("drain%0d_data", k), rd_data,
             (k < 8) ? (64'h3FF0000000000000 | 64'(k)) : 64'hC000000000000000);
         chk($sformatf("drain%0d_tag", k), 64'(rd_tag), (k < 8) ? 64'(k) : 64'h99);
         chk($sformatf("drain%0d_count", k), 64'(count), 64'(8 - k));
      end
      cyc();
      chk("drained_rv", 64'(rd_valid), 64'd0);
      chk("drained_empty", 64'(empty), 64'd1);
      chk("drained_hold", rd_data, 64'hC000000000000000);
      chk("no_stop_done", 64'(done), 64'd0);

      // ---------------- completion ----------------
      do_reset();
      drive(1'b1, 64'h3FF0000000000000, 8'hA1, 1'b0);
      cyc();
      drive(1'b1, 64'h4008000000000000, 8'hA2, 1'b0);
      cyc();
      drive(1'b0, 64'h0, 8'h0, 1'b0);
      stop_in = 1'b1;
      cyc();
      chk("cmp_stop_done", 64'(done), 64'd0);
      chk("cmp_stop_count", 64'(count), 64'd2);
      rd_en = 1'b1;
      cyc();
      chk("cmp_pop1_rv", 64'(rd_valid), 64'd1);
      chk("cmp_pop1_tag", 64'(rd_tag), 64'hA1);
      chk("cmp_pop1_done", 64'(done), 64'd0);
      cyc();
      chk("cmp_pop2_rv", 64'(rd_valid), 64'd1);
      chk("cmp_pop2_data", rd_data, 64'h4008000000000000);
      chk("cmp_pop2_done", 64'(done), 64'd0);
      rd_en = 1'b0;
      cyc();
      chk("cmp_done", 64'(done), 64'd1);
      chk("cmp_done_rv", 64'(rd_valid), 64'd0);
      drive(1'b1, 64'h3FF0000000000000, 8'hA3, 1'b0);
      cyc();
      chk("cmp_late_wr_count", 64'(count), 64'd1);
      chk("cmp_late_wr_done", 64'(done), 64'd1);

      // stop with nothing ever accepted, then async reset out of DONE
      do_reset();
      stop_in = 1'b1;
      cyc();
      chk("idle_stop_done", 64'(done), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_from_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      stop_in = 1'b0;

      // async reset in DRAIN
      do_reset();
      drive(1'b1, 64'h3FF0000000000000, 8'hB1, 1'b0);
      cyc();
      drive(1'b1, 64'h7FF8000000000000, 8'hB2, 1'b0);
      cyc();
      drive(1'b0, 64'h0, 8'h0, 1'b0);
      stop_in = 1'b1;
      cyc();
      chk("drain_pre_count", 64'(count), 64'd2);
      chk("drain_pre_nan", 64'(nan_flag), 64'd1);
      rst = 1'b1;
      #1;
      chk("drain_rst_done", 64'(done), 64'd0);
      chk("drain_rst_empty", 64'(empty), 64'd1);
      chk("drain_rst_count", 64'(count), 64'd0);
      chk("drain_rst_nan", 64'(nan_flag), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      stop_in = 1'b0;

      // ---------------- randomized run against queue model ----------------
      do_reset();
      mq.delete();
      m_rd = '0; m_rt = '0; m_rv = 1'b0; m_ovf = 1'b0; m_nan = 1'b0; m_inf = 1'b0; m_zc = 0;
      for (int n = 0; n < 3000; n++) begin
         int unsigned rd_pct;
         logic        pop, acc, wv, re;
         logic [63:0] d;
         logic [7:0]  t;
         rd_pct = (n < 1000) ? 25 : ((n < 2000) ? 75 : 50);
         wv = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < rd_pct);
         d  = gen_data();
         t  = 8'($urandom);
         drive(wv, d, t, re);
         cyc();
         pop = re && (mq.size() != 0);
         acc = wv && ((mq.size() < DEPTH) || re);
         m_rv = pop;
         if (pop) begin
            ent  = mq.pop_front();
            m_rd = ent[63:0];
            m_rt = ent[71:64];
         end
         if (acc) begin
            longint unsigned e, m;
            mq.push_back({t, d});
            e = (64'(d) >> 52) % 2048;
            m = 64'(d) % (64'd1 << 52);
            if (e == 2047 && m != 0) m_nan = 1'b1;
            if (e == 2047 && m == 0) m_inf = 1'b1;
            if (e == 0 && m == 0 && m_zc < 255) m_zc++;
         end else if (wv) begin
            m_ovf = 1'b1;
         end
         chk("rnd_count", 64'(count), 64'(mq.size()));
         chk("rnd_empty", 64'(empty), 64'(mq.size() == 0));
         chk("rnd_full", 64'(full), 64'(mq.size() == DEPTH));
         chk("rnd_rv", 64'(rd_valid), 64'(m_rv));
         chk("rnd_rd_data", rd_data, m_rd);
         chk("rnd_rd_tag", 64'(rd_tag), 64'(m_rt));
         chk("rnd_ovf", 64'(overflow), 64'(m_ovf));
         chk("rnd_nan", 64'(nan_flag), 64'(m_nan));
         chk("rnd_inf", 64'(inf_flag), 64'(m_inf));
         chk("rnd_zc", 64'(zero_cnt), 64'(m_zc));
         chk("rnd_done", 64'(done), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
